instr_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the single-cycle executor. Owns the PC, reads the

---
 rtl/arisco_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/arisco_pkg.sv
// Shared definitions for the arisco fetch/execute pipeline: data width,
// the canonical NOP encoding, the fetch-unit state encoding and a PC helper.
package arisco_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Force a byte address onto a word boundary; the low two bits are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-execute channel: {instr, instr_pc} on a valid/ready handshake
// flowing downstream, and branch/jump redirects flowing back upstream.
interface instr_fetch_unit_if;
    import arisco_pkg::*;

    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Fetch unit side.
    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // Executor side.
    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch buffer. Pointers wrap at DEPTH, count runs 0..DEPTH.
// Flush has priority over push and pop: it empties the buffer in one edge.
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? PW'(0) : ptr + PW'(1);
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = PW'(0);
            wr_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (push_i) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= PW'(0);
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to a synchronous
// program memory, buffers returned words with their PC in fetch_fifo and
// presents the head to the executor. Redirects flush the buffer and drop
// any in-flight return.
// Optional feature: define IFU_FETCH_COUNT_EN to add the fetch_count port,
// a free-running count of delivered instructions cleared only by reset.
module instr_fetch_unit
    import arisco_pkg::*;
#(
    parameter  int unsigned     PROG_WORDS = 64,
    parameter  int unsigned     FIFO_DEPTH = 2,
    parameter  logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    localparam int unsigned     AW         = $clog2(PROG_WORDS),
    localparam int unsigned     CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    instr_fetch_unit_if.master fe,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rdata
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [XLEN-1:0] fetch_count
`endif
);

    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    state_t          state_q,       state_d;
    logic [XLEN-1:0] req_pc_q,      req_pc_d;
    logic            inflight_q,    inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [2*XLEN-1:0] fifo_head_s;
    logic [CW-1:0]     fifo_count_s;
    logic              valid_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              redirect_s;
    logic [CW:0]       occ_s;

    assign redirect_s = fe.redirect_valid;
    assign valid_s    = (fifo_count_s != CW'(0));
    assign pop_s      = valid_s & fe.instr_ready;
    // A return arriving on a redirect edge belongs to the discarded path.
    assign push_s     = inflight_q & ~redirect_s;
    // Slots already spoken for after this edge; the pop frees one in time.
    assign occ_s      = {1'b0, fifo_count_s} + (CW + 1)'(inflight_q) - (CW + 1)'(pop_s);
    assign issue_s    = ~redirect_s & (occ_s < DEPTH_L);

    // Next-state for the FSM, request PC and in-flight tracking.
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            RESET:   state_d = redirect_s ? FLUSH : RUN;
            RUN:     state_d = redirect_s ? FLUSH : RUN;
            FLUSH:   state_d = redirect_s ? FLUSH : RUN;
            default: state_d = RESET;
        endcase
        if (redirect_s) begin
            req_pc_d   = word_align(fe.redirect_pc);
            inflight_d = 1'b0;
        end else if (issue_s) begin
            inflight_d    = 1'b1;
            inflight_pc_d = req_pc_q;
            req_pc_d      = req_pc_q + 32'd4;
        end else begin
            inflight_d = 1'b0;
        end
    end

    // FSM state, PC and in-flight registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RESET;
            req_pc_q      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i ({inflight_pc_q, imem_rdata}),
        .pop_i       (pop_s),
        .flush_i     (redirect_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    // Word index wraps naturally by truncation of the byte PC.
    assign imem_addr      = req_pc_q[AW+1:2];
    assign fe.instr_valid = valid_s;
    assign fe.instr       = valid_s ? fifo_head_s[XLEN-1:0]      : NOP_INSTR;
    assign fe.instr_pc    = valid_s ? fifo_head_s[2*XLEN-1:XLEN] : 32'h0000_0000;

`ifdef IFU_FETCH_COUNT_EN
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    // Delivered-instruction counter; redirects do not clear it.
    always_comb begin
        if (pop_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a synchronous program memory.
module tb_instr_fetch_unit;
    import arisco_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] mem [64];
`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int vectors;
    int errors;

    instr_fetch_unit_if fe_if ();

    instr_fetch_unit #(
        .PROG_WORDS (64),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fe         (fe_if),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata)
`ifdef IFU_FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data one cycle after the address is sampled.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return mem[pc[7:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fe_if.instr_ready = 1'b1;
        fe_if.redirect_valid = 1'b0;
        fe_if.redirect_pc = 32'h0;
        repeat (3) tick();
        vectors++; if (fe_if.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fe_if.instr_valid); end
        vectors++; if (fe_if.instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", fe_if.instr); end
        vectors++; if (fe_if.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", fe_if.instr_pc); end
        vectors++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
`ifdef IFU_FETCH_COUNT_EN
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`endif
    endtask

    task automatic test_stream();
        reset = 1'b0;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1_valid: got %b expected 0", fe_if.instr_valid); end
        vectors++; if (imem_addr !== 6'd1) begin errors++; $display("FAIL stream_edge1_addr: got %0d expected 1", imem_addr); end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'(4 * k) || fe_if.instr !== mem[k])
                begin errors++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", k, fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, 32'(4 * k), mem[k]); end
        end
    endtask

    task automatic test_stall();
        reset = 1'b1;
        tick();
        fe_if.instr_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'h0) begin errors++; $display("FAIL stall_first: got v=%b pc=%h expected v=1 pc=0", fe_if.instr_valid, fe_if.instr_pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'h0 || fe_if.instr !== mem[0] || imem_addr !== 6'd2)
                begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h addr=%0d expected v=1 pc=0 i=%h addr=2", i, fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, imem_addr, mem[0]); end
        end
        fe_if.instr_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'(4 * k) || fe_if.instr !== mem[k])
                begin errors++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h i=%h expected pc=%h i=%h", k, fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, 32'(4 * k), mem[k]); end
        end
    endtask

    task automatic test_reset_midrun();
        fe_if.instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0 || fe_if.instr !== 32'h0000_0013 || imem_addr !== 6'd0)
            begin errors++; $display("FAIL midreset_clear: got v=%b i=%h addr=%0d expected v=0 i=00000013 addr=0", fe_if.instr_valid, fe_if.instr, imem_addr); end
        reset = 1'b0;
        fe_if.instr_ready = 1'b1;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_edge1: got %b expected 0", fe_if.instr_valid); end
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'h0 || fe_if.instr !== mem[0])
            begin errors++; $display("FAIL midreset_refetch: got v=%b pc=%h i=%h expected v=1 pc=0 i=%h", fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, mem[0]); end
    endtask

    task automatic test_redirect();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fe_if.instr_ready = 1'b1;
        repeat (4) tick();
        vectors++; if (fe_if.instr_pc !== 32'h8) begin errors++; $display("FAIL redir_head: got %h expected 8", fe_if.instr_pc); end
        fe_if.redirect_valid = 1'b1;
        fe_if.redirect_pc = 32'h20;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0 || imem_addr !== 6'd8) begin errors++; $display("FAIL redir_flush: got v=%b addr=%0d expected v=0 addr=8", fe_if.instr_valid, imem_addr); end
        fe_if.redirect_valid = 1'b0;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got %b expected 0", fe_if.instr_valid); end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'(32 + 4 * k) || fe_if.instr !== exp_instr(32'(32 + 4 * k)))
                begin errors++; $display("FAIL redir_target[%0d]: got v=%b pc=%h i=%h expected pc=%h", k, fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, 32'(32 + 4 * k)); end
        end
    endtask

    task automatic test_redirect_align();
        fe_if.redirect_valid = 1'b1;
        fe_if.redirect_pc = 32'h23;
        tick();
        fe_if.redirect_valid = 1'b0;
        tick();
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'h20 || fe_if.instr !== mem[8])
            begin errors++; $display("FAIL align_pc: got v=%b pc=%h i=%h expected pc=20 i=%h", fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, mem[8]); end
        fe_if.redirect_valid = 1'b1;
        fe_if.redirect_pc = 32'h40;
        tick();
        fe_if.redirect_pc = 32'h10;
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b0 || imem_addr !== 6'd4) begin errors++; $display("FAIL b2b_flush: got v=%b addr=%0d expected v=0 addr=4", fe_if.instr_valid, imem_addr); end
        fe_if.redirect_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'(16 + 4 * k) || fe_if.instr !== mem[4 + k])
                begin errors++; $display("FAIL b2b_pc[%0d]: got v=%b pc=%h i=%h expected pc=%h", k, fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, 32'(16 + 4 * k)); end
        end
    endtask

    task automatic test_wrap();
        fe_if.redirect_valid = 1'b1;
        fe_if.redirect_pc = 32'hF8;
        tick();
        fe_if.redirect_valid = 1'b0;
        tick();
        tick();
        vectors++; if (fe_if.instr_pc !== 32'hF8 || fe_if.instr !== mem[62] || imem_addr !== 6'd0)
            begin errors++; $display("FAIL wrap_f8: got pc=%h i=%h addr=%0d expected pc=f8 i=%h addr=0", fe_if.instr_pc, fe_if.instr, imem_addr, mem[62]); end
        tick();
        vectors++; if (fe_if.instr_pc !== 32'hFC || fe_if.instr !== mem[63]) begin errors++; $display("FAIL wrap_fc: got pc=%h i=%h expected pc=fc i=%h", fe_if.instr_pc, fe_if.instr, mem[63]); end
        tick();
        vectors++; if (fe_if.instr_valid !== 1'b1 || fe_if.instr_pc !== 32'h100 || fe_if.instr !== mem[0])
            begin errors++; $display("FAIL wrap_100: got v=%b pc=%h i=%h expected pc=100 i=%h", fe_if.instr_valid, fe_if.instr_pc, fe_if.instr, mem[0]); end
    endtask

`ifdef IFU_FETCH_COUNT_EN
    task automatic test_fetch_count();
        reset = 1'b1;
        tick();
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL count_reset: got %0d expected 0", fetch_count); end
        reset = 1'b0;
        fe_if.instr_ready = 1'b1;
        tick();
        tick();
        repeat (7) tick();
        vectors++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL count_7: got %0d expected 7", fetch_count); end
        fe_if.redirect_valid = 1'b1;
        fe_if.redirect_pc = 32'h0;
        tick();
        fe_if.redirect_valid = 1'b0;
        vectors++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL count_redirect: got %0d expected 8", fetch_count); end
        reset = 1'b1;
        tick();
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL count_clear: got %0d expected 0", fetch_count); end
        reset = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        errors = 0;
        clk = 1'b0;
        reset = 1'b1;
        fe_if.instr_ready = 1'b0;
        fe_if.redirect_valid = 1'b0;
        fe_if.redirect_pc = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 + 32'(i * 32'h101);
        mem[0] = 32'h0010_0093;  // addi x1, x0, 1
        mem[1] = 32'h0020_0113;  // addi x2, x0, 2
        mem[2] = 32'h0030_0193;  // addi x3, x0, 3
        mem[3] = 32'h0010_F213;  // andi x4, x1, 1
        mem[4] = 32'h0020_E293;  // ori  x5, x1, 2
        test_reset();
        test_stream();
        test_stall();
        test_reset_midrun();
        test_redirect();
        test_redirect_align();
        test_wrap();
`ifdef IFU_FETCH_COUNT_EN
        test_fetch_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
